sim_state_writer: RTL

- Writer-side partner of the HPS-shared on-chip RAM port. The parameter logic reads HPS-written words from addresses 0-15; this block writes mass-spring state samples (x1, x2) back into a higher region of the same RAM for the HPS to read.
- Uses a double-buffered (ping-pong) layout with a header word. The HPS reads a completed bank while the FPGA fills the other.
- Sits in the CLOCK_50 domain. Samples arrive as single-cycle strobes, already synchronized from the slow simulation clock.

---
 rtl/sim_state_writer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/sim_state_writer.sv
`default_nettype none
// ============================================================================
// Module   : sim_state_writer
// Purpose  : Writes mass-spring state samples (x1, x2) into a ping-pong pair
//            of banks in the HPS-shared on-chip RAM, then commits each full
//            bank with a header word {bank, sequence}.
// Revision : 1.0 - initial release
// ============================================================================
module sim_state_writer #(
  parameter int ADDR_W    = 9,
  parameter int N_SAMPLES = 64,
  parameter int BASE_ADDR = 16
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              sample_valid,
  input  logic [9:0]        x1_in,
  input  logic [9:0]        x2_in,
  output logic              sample_ready,
  output logic [ADDR_W-1:0] ram_address,
  output logic [15:0]       ram_writedata,
  output logic              ram_write,
  output logic [1:0]        ram_byteenable,
  output logic              ram_clken,
  output logic              bank_done,
  output logic [15:0]       drop_count
);

  localparam int                c_idx_w     = $clog2(N_SAMPLES);
  localparam logic [ADDR_W-1:0] c_hdr_addr  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] c_data_base = ADDR_W'(BASE_ADDR + 1);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(N_SAMPLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WR_X1  = 2'd1,
    S_WR_X2  = 2'd2,
    S_WR_HDR = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_bank;
  logic [c_idx_w-1:0]  r_idx;
  logic [14:0]         r_seq;
  logic [9:0]          r_x2;
  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [15:0]         r_data;
  logic                r_bank_done;
  logic [15:0]         r_drop_count;

  logic                w_accept;
  logic                w_last;
  logic [14:0]         w_seq_next;
  logic [ADDR_W-1:0]   w_x1_addr;
  logic [15:0]         w_x1_ext;
  logic [15:0]         w_x2_ext;

  assign sample_ready   = (r_state == S_IDLE) && enable;
  assign w_accept       = sample_valid && sample_ready;
  assign w_last         = (r_idx == c_last_idx);
  assign w_seq_next     = r_seq + 15'd1;
  // N_SAMPLES is a power of two, so bank*2N + 2*idx is just a bit concatenation
  assign w_x1_addr      = c_data_base + ADDR_W'({r_bank, r_idx, 1'b0});
  assign w_x1_ext       = {{6{x1_in[9]}}, x1_in};
  assign w_x2_ext       = {{6{r_x2[9]}}, r_x2};

  assign ram_address    = r_addr;
  assign ram_writedata  = r_data;
  assign ram_write      = r_write;
  assign ram_byteenable = 2'b11;
  assign ram_clken      = 1'b1;
  assign bank_done      = r_bank_done;
  assign drop_count     = r_drop_count;

  // State register
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: two data words per sample, header only after the last sample
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next_state = S_WR_X1;
      S_WR_X1:  w_next_state = S_WR_X2;
      S_WR_X2:  w_next_state = w_last ? S_WR_HDR : S_IDLE;
      S_WR_HDR: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Write port registers and bank bookkeeping; outputs are set up one edge
  // ahead so each word is presented in the cycle of its state.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_bank      <= 1'b0;
      r_idx       <= '0;
      r_seq       <= '0;
      r_x2        <= '0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_bank_done <= 1'b0;
    end else begin
      r_write     <= 1'b0;
      r_bank_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_write <= 1'b1;
            r_addr  <= w_x1_addr;
            r_data  <= w_x1_ext;
            r_x2    <= x2_in;
          end
        end
        S_WR_X1: begin
          r_write <= 1'b1;
          r_addr  <= r_addr + ADDR_W'(1);
          r_data  <= w_x2_ext;
        end
        S_WR_X2: begin
          if (w_last) begin
            r_write     <= 1'b1;
            r_addr      <= c_hdr_addr;
            r_data      <= {r_bank, w_seq_next};
            r_bank_done <= 1'b1;
          end else begin
            r_idx <= r_idx + c_idx_w'(1);
          end
        end
        S_WR_HDR: begin
          // Header is out: this bank is committed, switch to the other one
          r_bank <= ~r_bank;
          r_idx  <= '0;
          r_seq  <= w_seq_next;
        end
        default: begin
          r_write <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of strobes that arrive while a sample is in flight
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_drop_count <= '0;
    end else if (sample_valid && (r_state != S_IDLE) && (r_drop_count != 16'hFFFF)) begin
      r_drop_count <= r_drop_count + 16'd1;
    end
  end

endmodule
`default_nettype wire
